// File: rtl/ticker_pkg.sv
// ticker_pkg -- shared definitions for the "dE1" ticker decoder.
//   Glyph patterns are active-low segment vectors indexed [0:6] = a..g,
//   written left to right as a..g in the literals below.
//   Also holds the 2-bit character codes, the six-frame rotation table,
//   the lock state enum and a mod-6 increment helper.
package ticker_pkg;

  // Active-low segment patterns, element 0 = segment a.
  localparam logic [0:6] GLYPH_D     = 7'b1000010;
  localparam logic [0:6] GLYPH_E     = 7'b0110000;
  localparam logic [0:6] GLYPH_ONE   = 7'b1001111;
  localparam logic [0:6] GLYPH_BLANK = 7'b1111111;

  localparam logic [1:0] CHR_D     = 2'b00;
  localparam logic [1:0] CHR_E     = 2'b01;
  localparam logic [1:0] CHR_ONE   = 2'b10;
  localparam logic [1:0] CHR_BLANK = 2'b11;

  localparam int NUM_DIGITS = 6;
  localparam int NUM_FRAMES = 6;

  // Rotation of "dE1   " across six digits, HEX5 in bits [11:10].
  localparam logic [11:0] FRAME_TABLE [NUM_FRAMES] = '{
    12'hFC6, 12'hF1B, 12'hC6F, 12'h1BF, 12'h6FC, 12'hBF1
  };

  localparam logic [11:0] CODE_RESET = 12'hFFF;

  typedef enum logic [1:0] {
    HUNT = 2'd0,
    ACQ  = 2'd1,
    LOCK = 2'd2
  } state_t;

  // Frame index successor, wrapping 5 -> 0.
  function automatic logic [2:0] next_idx(input logic [2:0] idx);
    return (idx == 3'd5) ? 3'd0 : idx + 3'd1;
  endfunction

endpackage

// File: rtl/ticker_7seg_decoder_if.sv
// ticker_7seg_decoder_if -- bundle of the decoder's data signals.
//   sample         : frame strobe
//   HEX5..HEX0     : active-low segment patterns [0:6] = a..g, HEX5 leftmost
//   code           : last decoded frame, 2 bits per digit, HEX5 in [11:10]
//   pos            : ticker position 0..5
//   locked         : high while in LOCK
//   err, wrap      : one-cycle pulses
//   err_cnt        : saturating error count (zero unless ERR_CNT_EN)
//   master drives sample/HEX*, slave (the decoder) drives the results.
interface ticker_7seg_decoder_if;
  logic        sample;
  logic [0:6]  HEX0;
  logic [0:6]  HEX1;
  logic [0:6]  HEX2;
  logic [0:6]  HEX3;
  logic [0:6]  HEX4;
  logic [0:6]  HEX5;
  logic [11:0] code;
  logic [2:0]  pos;
  logic        locked;
  logic        err;
  logic        wrap;
  logic [7:0]  err_cnt;

  modport master (
    output sample, HEX0, HEX1, HEX2, HEX3, HEX4, HEX5,
    input  code, pos, locked, err, wrap, err_cnt
  );

  modport slave (
    input  sample, HEX0, HEX1, HEX2, HEX3, HEX4, HEX5,
    output code, pos, locked, err, wrap, err_cnt
  );
endinterface

// File: rtl/seg7_char_dec.sv
// seg7_char_dec -- combinational decode of one active-low 7-segment
// pattern into a 2-bit character code.
//   seg   : input  [0:6] pattern, element 0 = segment a
//   chr   : output 2-bit character code (0 when invalid)
//   valid : output high when seg is one of the four known glyphs
module seg7_char_dec
  import ticker_pkg::*;
(
  input  logic [0:6] seg,
  output logic [1:0] chr,
  output logic       valid
);

  always_comb begin
    chr   = 2'b00;
    valid = 1'b0;
    case (seg)
      GLYPH_D: begin
        chr   = CHR_D;
        valid = 1'b1;
      end
      GLYPH_E: begin
        chr   = CHR_E;
        valid = 1'b1;
      end
      GLYPH_ONE: begin
        chr   = CHR_ONE;
        valid = 1'b1;
      end
      GLYPH_BLANK: begin
        chr   = CHR_BLANK;
        valid = 1'b1;
      end
      default: begin
        chr   = 2'b00;
        valid = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/ticker_7seg_decoder.sv
// ticker_7seg_decoder -- tracks a "dE1" ticker scrolling across six
// 7-segment digits and reports lock, position, wrap and errors.
//   CLOCK_50 : clock, all state on rising edge
//   reset    : synchronous active-high reset (beats sample)
//   bus      : ticker_7seg_decoder_if.slave (sample, HEX5..HEX0 in;
//              code, pos, locked, err, wrap, err_cnt out)
// Optional feature macro: ERR_CNT_EN builds the saturating error counter;
// without it err_cnt is tied to zero.
module ticker_7seg_decoder
  import ticker_pkg::*;
(
  input  logic                  CLOCK_50,
  input  logic                  reset,
  ticker_7seg_decoder_if.slave  bus
);

  // ---------------- glyph decode ----------------
  logic [0:6]  hex_arr [NUM_DIGITS];
  logic [1:0]  chr_arr [NUM_DIGITS];
  logic [5:0]  valid_vec;
  logic [11:0] frame_val;
  logic        all_valid;

  assign hex_arr[0] = bus.HEX0;
  assign hex_arr[1] = bus.HEX1;
  assign hex_arr[2] = bus.HEX2;
  assign hex_arr[3] = bus.HEX3;
  assign hex_arr[4] = bus.HEX4;
  assign hex_arr[5] = bus.HEX5;

  generate
    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_dec
      seg7_char_dec u_dec (
        .seg   (hex_arr[gi]),
        .chr   (chr_arr[gi]),
        .valid (valid_vec[gi])
      );
      // HEX0 lands in the low bits, HEX5 in [11:10].
      assign frame_val[gi*2 +: 2] = chr_arr[gi];
    end
  endgenerate

  assign all_valid = &valid_vec;

  // ---------------- frame table lookup ----------------
  logic       frame_hit;
  logic [2:0] frame_k;

  always_comb begin
    frame_hit = 1'b0;
    frame_k   = 3'd0;
    for (int i = 0; i < NUM_FRAMES; i++) begin
      if (frame_val == FRAME_TABLE[i]) begin
        frame_hit = 1'b1;
        frame_k   = i[2:0];
      end
    end
  end

  // A frame counts only if every glyph decoded and the value is in the table.
  logic frame_ok;
  assign frame_ok = all_valid && frame_hit;

  // ---------------- state ----------------
  state_t      state_reg, state_next;
  logic [2:0]  kp_reg, kp_next;
  logic [2:0]  pos_reg, pos_next;
  logic [11:0] code_reg, code_next;
  logic        err_reg, err_next;
  logic        wrap_reg, wrap_next;

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_reg <= HUNT;
      kp_reg    <= 3'd0;
      pos_reg   <= 3'd0;
      code_reg  <= CODE_RESET;
      err_reg   <= 1'b0;
      wrap_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      kp_reg    <= kp_next;
      pos_reg   <= pos_next;
      code_reg  <= code_next;
      err_reg   <= err_next;
      wrap_reg  <= wrap_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    kp_next    = kp_reg;
    pos_next   = pos_reg;
    code_next  = code_reg;
    err_next   = 1'b0;
    wrap_next  = 1'b0;

    if (bus.sample) begin
      // code tracks any fully decodable frame, known to the table or not.
      if (all_valid) begin
        code_next = frame_val;
      end

      case (state_reg)
        HUNT: begin
          if (frame_ok) begin
            state_next = ACQ;
            kp_next    = frame_k;
            pos_next   = frame_k;
          end else begin
            err_next = 1'b1;
          end
        end

        ACQ: begin
          if (!frame_ok) begin
            state_next = HUNT;
            err_next   = 1'b1;
          end else if (frame_k == kp_reg) begin
            state_next = ACQ;
          end else if (frame_k == next_idx(kp_reg)) begin
            state_next = LOCK;
            kp_next    = frame_k;
            pos_next   = frame_k;
          end else begin
            // Out-of-order but legal frame: restart acquisition from it.
            kp_next = frame_k;
          end
        end

        LOCK: begin
          if (frame_ok && (frame_k == kp_reg)) begin
            // Repeated frame: sampling faster than the ticker moves.
            state_next = LOCK;
          end else if (frame_ok && (frame_k == next_idx(kp_reg))) begin
            kp_next   = frame_k;
            pos_next  = frame_k;
            wrap_next = (kp_reg == 3'd5);
          end else begin
            state_next = HUNT;
            err_next   = 1'b1;
          end
        end

        default: begin
          state_next = HUNT;
        end
      endcase
    end
  end

  assign bus.code   = code_reg;
  assign bus.pos    = pos_reg;
  assign bus.locked = (state_reg == LOCK);
  assign bus.err    = err_reg;
  assign bus.wrap   = wrap_reg;

  // ---------------- optional error counter ----------------
`ifdef ERR_CNT_EN
  logic [7:0] err_cnt_reg;

  // Counts err_next so the count moves on the same edge as the err pulse.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      err_cnt_reg <= 8'd0;
    end else if (err_next && (err_cnt_reg != 8'hFF)) begin
      err_cnt_reg <= err_cnt_reg + 8'd1;
    end
  end

  assign bus.err_cnt = err_cnt_reg;
`else
  assign bus.err_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_ticker_7seg_decoder.sv
// tb_ticker_7seg_decoder -- table-driven bench for ticker_7seg_decoder.
// Inputs change on the falling edge; outputs are checked 1 ns after the
// rising edge that consumes them. ERR_CNT_EN selects the counter checks.
module tb_ticker_7seg_decoder;

  logic clk = 1'b0;
  logic reset;

  ticker_7seg_decoder_if bus ();

  ticker_7seg_decoder dut (
    .CLOCK_50 (clk),
    .reset    (reset),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  int total_checks  = 0;
  int passed_checks = 0;

  typedef struct packed {
    logic        rst;
    logic        smp;
    logic [11:0] frame;
    logic        bad3;
    logic [11:0] c;
    logic [2:0]  p;
    logic        lk;
    logic        e;
    logic        w;
  } vec_t;

  localparam int NV = 24;
  vec_t vecs [NV];

  // Active-low pattern for a 2-bit char code, leftmost literal bit = segment a.
  function automatic logic [6:0] glyph(input logic [1:0] c);
    case (c)
      2'b00:   return 7'b1000010;
      2'b01:   return 7'b0110000;
      2'b10:   return 7'b1001111;
      default: return 7'b1111111;
    endcase
  endfunction

  task automatic drive(input logic r, input logic s, input logic [11:0] f, input logic bad3);
    reset      = r;
    bus.sample = s;
    bus.HEX0   = glyph(f[1:0]);
    bus.HEX1   = glyph(f[3:2]);
    bus.HEX2   = glyph(f[5:4]);
    bus.HEX3   = bad3 ? 7'b0000000 : glyph(f[7:6]);
    bus.HEX4   = glyph(f[9:8]);
    bus.HEX5   = glyph(f[11:10]);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total_checks++;
    if (act !== exp)
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    else
      passed_checks++;
  endtask

  logic [7:0] exp_cnt;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    //               rst   smp   frame    bad3  code     pos   lk    err   wrap
    vecs[0]  = '{1'b1, 1'b0, 12'h000, 1'b0, 12'hFFF, 3'd0, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{1'b0, 1'b1, 12'hFC6, 1'b0, 12'hFC6, 3'd0, 1'b0, 1'b0, 1'b0};
    vecs[2]  = '{1'b0, 1'b1, 12'hF1B, 1'b0, 12'hF1B, 3'd1, 1'b1, 1'b0, 1'b0};
    vecs[3]  = '{1'b0, 1'b0, 12'hC6F, 1'b0, 12'hF1B, 3'd1, 1'b1, 1'b0, 1'b0};
    vecs[4]  = '{1'b0, 1'b1, 12'h6FC, 1'b0, 12'h6FC, 3'd1, 1'b0, 1'b1, 1'b0};
    vecs[5]  = '{1'b0, 1'b0, 12'h6FC, 1'b0, 12'h6FC, 3'd1, 1'b0, 1'b0, 1'b0};
    vecs[6]  = '{1'b0, 1'b1, 12'h1BF, 1'b0, 12'h1BF, 3'd3, 1'b0, 1'b0, 1'b0};
    vecs[7]  = '{1'b0, 1'b1, 12'h6FC, 1'b0, 12'h6FC, 3'd4, 1'b1, 1'b0, 1'b0};
    vecs[8]  = '{1'b0, 1'b1, 12'hBF1, 1'b0, 12'hBF1, 3'd5, 1'b1, 1'b0, 1'b0};
    vecs[9]  = '{1'b0, 1'b1, 12'hFC6, 1'b0, 12'hFC6, 3'd0, 1'b1, 1'b0, 1'b1};
    vecs[10] = '{1'b0, 1'b1, 12'hF1B, 1'b0, 12'hF1B, 3'd1, 1'b1, 1'b0, 1'b0};
    vecs[11] = '{1'b0, 1'b1, 12'hC6F, 1'b0, 12'hC6F, 3'd2, 1'b1, 1'b0, 1'b0};
    vecs[12] = '{1'b0, 1'b1, 12'hC6F, 1'b0, 12'hC6F, 3'd2, 1'b1, 1'b0, 1'b0};
    vecs[13] = '{1'b0, 1'b1, 12'hC6F, 1'b0, 12'hC6F, 3'd2, 1'b1, 1'b0, 1'b0};
    vecs[14] = '{1'b0, 1'b1, 12'hF1B, 1'b1, 12'hC6F, 3'd2, 1'b0, 1'b1, 1'b0};
    vecs[15] = '{1'b0, 1'b1, 12'hF1B, 1'b1, 12'hC6F, 3'd2, 1'b0, 1'b1, 1'b0};
    vecs[16] = '{1'b0, 1'b1, 12'h000, 1'b0, 12'h000, 3'd2, 1'b0, 1'b1, 1'b0};
    vecs[17] = '{1'b0, 1'b1, 12'hFC6, 1'b0, 12'hFC6, 3'd0, 1'b0, 1'b0, 1'b0};
    vecs[18] = '{1'b0, 1'b1, 12'hFC6, 1'b0, 12'hFC6, 3'd0, 1'b0, 1'b0, 1'b0};
    vecs[19] = '{1'b0, 1'b1, 12'hF1B, 1'b0, 12'hF1B, 3'd1, 1'b1, 1'b0, 1'b0};
    vecs[20] = '{1'b1, 1'b1, 12'h1BF, 1'b0, 12'hFFF, 3'd0, 1'b0, 1'b0, 1'b0};
    vecs[21] = '{1'b0, 1'b1, 12'hC6F, 1'b0, 12'hC6F, 3'd2, 1'b0, 1'b0, 1'b0};
    vecs[22] = '{1'b0, 1'b1, 12'h1BF, 1'b0, 12'h1BF, 3'd3, 1'b1, 1'b0, 1'b0};
    vecs[23] = '{1'b0, 1'b1, 12'h6FC, 1'b1, 12'h1BF, 3'd3, 1'b0, 1'b1, 1'b0};

    drive(1'b1, 1'b0, 12'hFFF, 1'b0);
    exp_cnt = 8'd0;
    repeat (2) @(posedge clk);

    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      drive(vecs[i].rst, vecs[i].smp, vecs[i].frame, vecs[i].bad3);
      @(posedge clk);
      #1;
      if (vecs[i].rst) exp_cnt = 8'd0;
      else if (vecs[i].e && exp_cnt != 8'hFF) exp_cnt = exp_cnt + 8'd1;
      $display("row %0d rst=%0b smp=%0b frame=%h bad3=%0b -> code=%h pos=%0d locked=%0b err=%0b wrap=%0b err_cnt=%0d",
               i, vecs[i].rst, vecs[i].smp, vecs[i].frame, vecs[i].bad3,
               bus.code, bus.pos, bus.locked, bus.err, bus.wrap, bus.err_cnt);
      chk($sformatf("row%0d_code", i),   32'(bus.code),   32'(vecs[i].c));
      chk($sformatf("row%0d_pos", i),    32'(bus.pos),    32'(vecs[i].p));
      chk($sformatf("row%0d_locked", i), 32'(bus.locked), 32'(vecs[i].lk));
      chk($sformatf("row%0d_err", i),    32'(bus.err),    32'(vecs[i].e));
      chk($sformatf("row%0d_wrap", i),   32'(bus.wrap),   32'(vecs[i].w));
`ifdef ERR_CNT_EN
      chk($sformatf("row%0d_err_cnt", i), 32'(bus.err_cnt), 32'(exp_cnt));
`else
      chk($sformatf("row%0d_err_cnt", i), 32'(bus.err_cnt), 32'd0);
`endif
    end

    // Long run of bad-glyph samples: err stays asserted every cycle,
    // code holds, and the counter saturates.
    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      drive(1'b0, 1'b1, 12'hC6F, 1'b1);
      @(posedge clk);
      #1;
      if (n == 0 || n == 299) begin
        $display("badrun %0d -> code=%h err=%0b locked=%0b err_cnt=%0d",
                 n, bus.code, bus.err, bus.locked, bus.err_cnt);
        chk($sformatf("badrun%0d_err", n),  32'(bus.err),  32'd1);
        chk($sformatf("badrun%0d_code", n), 32'(bus.code), 32'h1BF);
      end
    end
`ifdef ERR_CNT_EN
    chk("badrun_err_cnt_sat", 32'(bus.err_cnt), 32'd255);
`else
    chk("badrun_err_cnt_zero", 32'(bus.err_cnt), 32'd0);
`endif

    // Strobe drops: err falls back to 0 and everything holds.
    @(negedge clk);
    drive(1'b0, 1'b0, 12'hFC6, 1'b0);
    @(posedge clk);
    #1;
    $display("idle -> code=%h err=%0b err_cnt=%0d", bus.code, bus.err, bus.err_cnt);
    chk("idle_err",  32'(bus.err),  32'd0);
    chk("idle_code", 32'(bus.code), 32'h1BF);

    // Reset clears the counter.
    @(negedge clk);
    drive(1'b1, 1'b0, 12'hFC6, 1'b0);
    @(posedge clk);
    #1;
    $display("reset -> code=%h pos=%0d err_cnt=%0d", bus.code, bus.pos, bus.err_cnt);
    chk("final_reset_cnt",  32'(bus.err_cnt), 32'd0);
    chk("final_reset_code", 32'(bus.code),    32'hFFF);

    $display("%0d/%0d checks passed", passed_checks, total_checks);
    $finish;
  end

endmodule

// File: doc/ticker_7seg_decoder.md
TICKER_7SEG_DECODER -- requirements
Module: ticker_7seg_decoder

Interface
REQ-001 CLOCK_50  input  1  sole clock; all state changes on its rising edge.
REQ-002 reset  input  1  synchronous, active-high reset.
REQ-003 sample  input  1  frame strobe; the HEX inputs are evaluated only in cycles where it is high.
REQ-004 HEX5..HEX0  input  7 each, [0:6]  active-low segment patterns, bit0=a .. bit6=g; HEX5 is the leftmost digit.
REQ-005 code  output  12  last decoded frame: {HEX5..HEX0} as 2-bit char codes, HEX5 in [11:10].
REQ-006 pos  output  3  current ticker position, 0..5.
REQ-007 locked  output  1  high while the state machine is in LOCK.
REQ-008 err  output  1  one-cycle pulse on any decode or sequence error.
REQ-009 wrap  output  1  one-cycle pulse on a LOCK transition from pos 5 to pos 0.
REQ-010 err_cnt  output  8  saturating error count (see Configuration).

Function
REQ-011 Glyph map [0:6] SHALL be: "1000010"=d=00, "0110000"=E=01, "1001111"=1=10, "1111111"=blank=11; any other pattern is invalid.
REQ-012 Frame table by index k, as 12-bit codes: 0=FC6, 1=F1B, 2=C6F, 3=1BF, 4=6FC, 5=BF1; any other 12-bit value is an unknown frame.
REQ-013 A sampled frame is valid only if all six glyphs are valid and the 12-bit value matches a table entry k.
REQ-014 Latency: code, pos, locked, err and wrap SHALL update on the clock edge at the end of the sample cycle (1 cycle); with sample low, all outputs hold and err/wrap are 0.
REQ-015 code SHALL load on every sample that has all glyphs valid; on an invalid glyph, code SHALL hold.
REQ-016 States are HUNT, ACQ and LOCK; the block stores the last valid index as kp.
REQ-017 HUNT: valid frame k -> ACQ, kp=k, pos=k; invalid frame -> stay in HUNT with an err pulse.
REQ-018 ACQ: k==kp -> stay; k==(kp+1) mod 6 -> LOCK, pos=k; any other valid k -> stay in ACQ, kp=k, no err; invalid frame -> HUNT with an err pulse.
REQ-019 LOCK: k==kp -> hold, since repeated frames are legal when sampling faster than the ticker; k==(kp+1) mod 6 -> advance pos; anything else -> HUNT with an err pulse and pos held.
REQ-020 Index arithmetic is mod 6, so 5+1=0; the 5->0 advance in LOCK pulses wrap.
REQ-021 locked SHALL deassert in the same cycle err pulses out of LOCK.

Reset
REQ-022 reset SHALL force HUNT, kp=0, code=FFF, pos=0, locked=0, err=0, wrap=0, err_cnt=0.
REQ-023 reset SHALL take priority over sample in the same cycle.
REQ-024 reset asserted mid-rotation SHALL require fresh acquisition (two consecutive sequential frames) before locked rises again.

Configuration
REQ-025 ERR_CNT_EN defined: err_cnt SHALL increment on every err pulse, saturate at 255, and clear only on reset.
REQ-026 ERR_CNT_EN undefined: err_cnt SHALL be tied to 0, no counter logic is built, and all other behaviour is unchanged.

Structure
REQ-027 Package ticker_pkg SHALL hold the four glyph constants, their 2-bit codes, the six-entry frame table and the state enum (HUNT/ACQ/LOCK).
REQ-028 One sub-module, seg7_char_dec, SHALL be combinational (7-bit pattern -> 2-bit code + valid) and is instantiated six times; all state lives in the top.

Verification
REQ-029 Reset, then sample frames FC6, F1B -> after frame 2: locked=1, pos=1, err=0.
REQ-030 Locked, then walk through 6FC, BF1, FC6 -> pos goes 4, 5, 0; wrap pulses once on 0; locked stays 1.
REQ-031 Locked at pos 2, then sample C6F three times -> pos stays 2, locked=1, no err.
REQ-032 Locked at pos 1, then sample 6FC (skip) -> err pulses for one cycle, locked=0, state HUNT, pos holds 1.
REQ-033 Sample with HEX3="0000000" -> err=1, code unchanged; with ERR_CNT_EN, 300 such samples -> err_cnt=255.
REQ-034 Assert reset in the same cycle as sample with valid frame 3 -> all outputs at reset values, state HUNT.
